// File: rtl/video_ctrl_pkg.sv
// Shared constants and types for the video mode control plane.
package video_ctrl_pkg;

    localparam int NUM_BTN = 3;
    localparam int BTN_BG  = 0;
    localparam int BTN_TGT = 1;
    localparam int BTN_CH  = 2;

    localparam logic [2:0] CH_R   = 3'd0;
    localparam logic [2:0] CH_G   = 3'd1;
    localparam logic [2:0] CH_B   = 3'd2;
    localparam logic [2:0] CH_Y   = 3'd3;
    localparam logic [2:0] CH_CR  = 3'd4;
    localparam logic [2:0] CH_CB  = 3'd5;
    localparam logic [2:0] CH_MAX = CH_CB;

    typedef enum logic {
        XH_STEADY = 1'b0,
        XH_BLINK  = 1'b1
    } xh_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge pulse
// for one pushbutton.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            level_d <= level_q;
            // Any cycle agreeing with the current level restarts the count.
            if (sync_q[1] == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q[1];
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level_q & ~level_d;

endmodule

// File: rtl/video_mode_ctrl.sv
// Button-driven mode sequencer for the video mux: stages selections and
// commits them at frame boundaries; blinks the crosshair after target changes.
module video_mode_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_PERIOD    = 8,
    parameter int BLINK_HALVES    = 6
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       btn_bg_in,
    input  logic       btn_target_in,
    input  logic       btn_channel_in,
    input  logic       freeze_in,
    input  logic       new_frame_in,
    output logic [1:0] bg_out,
    output logic [1:0] target_out,
    output logic [2:0] channel_sel_out,
    output logic       crosshair_en_out,
    output logic       pending_out
);

    localparam int FRM_W  = $clog2(BLINK_PERIOD + 1);
    localparam int HALF_W = $clog2(BLINK_HALVES + 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] adv;

    assign btn_raw = {btn_channel_in, btn_target_in, btn_bg_in};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk_in),
            .rst_n   (rst_n_in),
            .btn_raw (btn_raw[i]),
            .rise    (btn_rise[i])
        );
    end

    assign adv = btn_rise & {NUM_BTN{~freeze_in}};

    logic [1:0] bg_stage;
    logic [1:0] target_stage;
    logic [2:0] chan_stage;

    // Commit reads the pre-increment stage, so a same-cycle press lands next frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bg_stage        <= '0;
            target_stage    <= '0;
            chan_stage      <= CH_R;
            bg_out          <= '0;
            target_out      <= '0;
            channel_sel_out <= CH_R;
        end else begin
            if (adv[BTN_BG])  bg_stage     <= bg_stage + 2'd1;
            if (adv[BTN_TGT]) target_stage <= target_stage + 2'd1;
            if (adv[BTN_CH])  chan_stage   <= (chan_stage == CH_MAX) ? CH_R : chan_stage + 3'd1;
            if (new_frame_in) begin
                bg_out          <= bg_stage;
                target_out      <= target_stage;
                channel_sel_out <= chan_stage;
            end
        end
    end

    assign pending_out = (bg_stage != bg_out) | (target_stage != target_out) |
                         (chan_stage != channel_sel_out);

    xh_state_e   state_q, state_nxt;
    logic [FRM_W-1:0]  frame_q, frame_nxt;
    logic [HALF_W-1:0] half_q, half_nxt;
    logic        xh_nxt;
    logic        tgt_commit;

    assign tgt_commit = new_frame_in & (target_stage != target_out);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= XH_STEADY;
            frame_q          <= '0;
            half_q           <= '0;
            crosshair_en_out <= 1'b1;
        end else begin
            state_q          <= state_nxt;
            frame_q          <= frame_nxt;
            half_q           <= half_nxt;
            crosshair_en_out <= xh_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        frame_nxt = frame_q;
        half_nxt  = half_q;
        if (tgt_commit) begin
            state_nxt = XH_BLINK;
            frame_nxt = '0;
            half_nxt  = '0;
        end else if (state_q == XH_BLINK && new_frame_in) begin
            if (frame_q == FRM_W'(BLINK_PERIOD - 1)) begin
                frame_nxt = '0;
                half_nxt  = half_q + 1'b1;
                if (half_q == HALF_W'(BLINK_HALVES - 1)) state_nxt = XH_STEADY;
            end else begin
                frame_nxt = frame_q + 1'b1;
            end
        end
    end

    // Burst always ends lit, whatever the parity of BLINK_HALVES.
    always_comb begin
        xh_nxt = crosshair_en_out;
        if (state_nxt == XH_STEADY)  xh_nxt = 1'b1;
        else if (tgt_commit)         xh_nxt = 1'b0;
        else if (half_nxt != half_q) xh_nxt = ~crosshair_en_out;
    end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed scenarios plus a randomized run against a frame-level reference model.
module tb_video_mode_ctrl;

    localparam int DB = 4;
    localparam int BP = 2;
    localparam int BH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_bg = 1'b0, btn_tg = 1'b0, btn_ch = 1'b0, freeze = 1'b0, nf = 1'b0;
    logic [1:0] bg_out, target_out;
    logic [2:0] chan_out;
    logic       xh, pend;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_PERIOD(BP), .BLINK_HALVES(BH)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .btn_bg_in        (btn_bg),
        .btn_target_in    (btn_tg),
        .btn_channel_in   (btn_ch),
        .freeze_in        (freeze),
        .new_frame_in     (nf),
        .bg_out           (bg_out),
        .target_out       (target_out),
        .channel_sel_out  (chan_out),
        .crosshair_en_out (xh),
        .pending_out      (pend)
    );

    // Reference model: a button counts as pressed once its raw level, seen two
    // cycles late, has held a new value for DB cycles; the press is applied one
    // cycle later. Crosshair state is "frames since last target commit".
    logic [2:0] h1, h2, lvl, rise, raw;
    int run [3];
    int m_bg_s, m_tg_s, m_ch_s, m_bg_o, m_tg_o, m_ch_o;
    bit m_act;
    int m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 = '0; h2 = '0; lvl = '0; rise = '0;
            for (int i = 0; i < 3; i++) run[i] = 0;
            m_bg_s = 0; m_tg_s = 0; m_ch_s = 0; m_bg_o = 0; m_tg_o = 0; m_ch_o = 0;
            m_act = 0; m_k = 0;
        end else begin
            raw = {btn_ch, btn_tg, btn_bg};
            if (nf) begin
                if (m_tg_s != m_tg_o) begin
                    m_act = 1; m_k = 0;
                end else if (m_act) begin
                    m_k++;
                    if (m_k >= BP * BH) m_act = 0;
                end
                m_bg_o = m_bg_s; m_tg_o = m_tg_s; m_ch_o = m_ch_s;
            end
            if (!freeze) begin
                if (rise[0]) m_bg_s = (m_bg_s + 1) % 4;
                if (rise[1]) m_tg_s = (m_tg_s + 1) % 4;
                if (rise[2]) m_ch_s = (m_ch_s + 1) % 6;
            end
            for (int i = 0; i < 3; i++) begin
                rise[i] = 1'b0;
                if (h2[i] != lvl[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == DB) begin
                    lvl[i] = h2[i];
                    run[i] = 0;
                    rise[i] = h2[i];
                end
            end
            h2 = h1;
            h1 = raw;
        end
    end

    function automatic logic [8:0] model_outs();
        logic en;
        logic pd;
        en = m_act ? (((m_k / BP) % 2) == 1) : 1'b1;
        pd = (m_bg_s != m_bg_o) || (m_tg_s != m_tg_o) || (m_ch_s != m_ch_o);
        return {2'(m_bg_o), 2'(m_tg_o), 3'(m_ch_o), en, pd};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        {btn_bg, btn_tg, btn_ch, freeze, nf} = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic frame();
        nf = 1'b1;
        tick();
        nf = 1'b0;
    endtask

    task automatic press(input int idx);
        if (idx == 0) btn_bg = 1'b1; else if (idx == 1) btn_tg = 1'b1; else btn_ch = 1'b1;
        repeat (10) tick();
        {btn_bg, btn_tg, btn_ch} = '0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bg_out, target_out, chan_out, xh, pend} !== 9'h002) begin
            errors++; $display("FAIL reset_hold: got %h want 002", {bg_out, target_out, chan_out, xh, pend});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bg_out, target_out, chan_out, xh, pend} !== 9'h002) begin
            errors++; $display("FAIL reset_release: got %h want 002", {bg_out, target_out, chan_out, xh, pend});
        end
    endtask

    task automatic test_bg_commit();
        do_reset();
        btn_bg = 1'b1;
        repeat (6) tick();
        checks++;
        if (pend !== 1'b0) begin errors++; $display("FAIL press_early: pending %b want 0", pend); end
        tick();
        checks++;
        if (pend !== 1'b1) begin errors++; $display("FAIL press_latency: pending %b want 1", pend); end
        repeat (13) tick();
        btn_bg = 1'b0;
        repeat (10) tick();
        checks++;
        if (bg_out !== 2'd0 || pend !== 1'b1) begin
            errors++; $display("FAIL bg_precommit: bg %0d pend %b want 0 1", bg_out, pend);
        end
        frame();
        checks++;
        if (bg_out !== 2'd1 || pend !== 1'b0 || xh !== 1'b1) begin
            errors++; $display("FAIL bg_commit: bg %0d pend %b xh %b want 1 0 1", bg_out, pend, xh);
        end
    endtask

    task automatic test_bounce_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_ch = ~btn_ch;
            repeat (2) tick();
        end
        btn_ch = 1'b0;
        repeat (10) tick();
        checks++;
        if (pend !== 1'b0) begin errors++; $display("FAIL bounce_stage: pending %b want 0", pend); end
        frame();
        checks++;
        if (chan_out !== 3'd0) begin errors++; $display("FAIL bounce_commit: chan %0d want 0", chan_out); end
        repeat (7) press(2);
        frame();
        checks++;
        if (chan_out !== 3'd1 || pend !== 1'b0) begin
            errors++; $display("FAIL chan_wrap: chan %0d pend %b want 1 0", chan_out, pend);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        btn_tg = 1'b1;
        repeat (6) tick();
        nf = 1'b1;
        tick();
        nf = 1'b0;
        checks++;
        if (target_out !== 2'd0 || pend !== 1'b1) begin
            errors++; $display("FAIL same_cycle: target %0d pend %b want 0 1", target_out, pend);
        end
        repeat (6) tick();
        btn_tg = 1'b0;
        repeat (10) tick();
        frame();
        checks++;
        if (target_out !== 2'd1 || xh !== 1'b0) begin
            errors++; $display("FAIL next_frame: target %0d xh %b want 1 0", target_out, xh);
        end
    endtask

    task automatic test_blink();
        bit exp_seq [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        press(1);
        frame();
        repeat (3) tick();
        checks++;
        if (xh !== exp_seq[0]) begin errors++; $display("FAIL blink_f0: xh %b want %b", xh, exp_seq[0]); end
        for (int f = 1; f < 9; f++) begin
            frame();
            repeat (3) tick();
            checks++;
            if (xh !== exp_seq[f]) begin errors++; $display("FAIL blink_f%0d: xh %b want %b", f, xh, exp_seq[f]); end
        end
        frame();
        checks++;
        if (xh !== 1'b1) begin errors++; $display("FAIL blink_steady: xh %b want 1", xh); end
        press(1);
        frame();
        frame();
        frame();
        press(1);
        frame();
        checks++;
        if (xh !== 1'b0 || target_out !== 2'd3) begin
            errors++; $display("FAIL blink_restart: xh %b target %0d want 0 3", xh, target_out);
        end
        for (int f = 1; f < 9; f++) begin
            frame();
            checks++;
            if (xh !== exp_seq[f]) begin errors++; $display("FAIL restart_f%0d: xh %b want %b", f, xh, exp_seq[f]); end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        freeze = 1'b1;
        press(0);
        freeze = 1'b0;
        checks++;
        if (pend !== 1'b0) begin errors++; $display("FAIL freeze_stage: pending %b want 0", pend); end
        frame();
        checks++;
        if (bg_out !== 2'd0) begin errors++; $display("FAIL freeze_commit: bg %0d want 0", bg_out); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(0);
        press(1);
        press(2);
        frame();
        press(0);
        checks++;
        if ({xh, pend} !== 2'b01 || bg_out !== 2'd1) begin
            errors++; $display("FAIL pre_reset: xh %b pend %b bg %0d want 0 1 1", xh, pend, bg_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bg_out, target_out, chan_out, xh, pend} !== 9'h002) begin
            errors++; $display("FAIL async_reset: got %h want 002", {bg_out, target_out, chan_out, xh, pend});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int hold [3];
        logic [8:0] exp;
        logic [2:0] b;
        do_reset();
        for (int i = 0; i < 3; i++) hold[i] = 0;
        b = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    b[i] = ~b[i];
                    hold[i] = $urandom_range(1, 12);
                end else begin
                    hold[i]--;
                end
            end
            {btn_ch, btn_tg, btn_bg} = b;
            freeze = ($urandom_range(0, 9) == 0);
            nf = ($urandom_range(0, 5) == 0);
            tick();
            exp = model_outs();
            checks++;
            if ({bg_out, target_out, chan_out, xh, pend} !== exp) begin
                errors++;
                $display("FAIL random c%0d: got %h want %h", c, {bg_out, target_out, chan_out, xh, pend}, exp);
            end
        end
        {btn_bg, btn_tg, btn_ch, freeze, nf} = '0;
    endtask

    initial begin
        test_reset();
        test_bg_commit();
        test_bounce_wrap();
        test_same_cycle();
        test_blink();
        test_freeze();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Control-plane sequencer for the pixel-path video mux. It debounces the three user pushbuttons and advances the background mode, target mode and colour-channel selection. It stages every change and commits it only at a frame boundary, so the mux never switches sources mid-frame. It also generates the crosshair enable, which blinks for a fixed number of frames after each target-mode change. It sits in the pixel clock domain, between the board buttons and the select inputs of the video mux and the channel-selection module.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required before a debounced level changes.
- BLINK_PERIOD, default 8: frames per crosshair on/off half-period.
- BLINK_HALVES, default 6: half-periods per blink burst.

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- btn_bg_in  input  1  raw button; advances background mode
- btn_target_in  input  1  raw button; advances target mode
- btn_channel_in  input  1  raw button; advances channel selection
- freeze_in  input  1  while high, all button edges are ignored
- new_frame_in  input  1  one-cycle pulse at start of vertical blank
- bg_out  output  2  committed background select for the mux
- target_out  output  2  committed target select for the mux
- channel_sel_out  output  3  committed channel code, 0..5 = R, G, B, Y, Cr, Cb
- crosshair_en_out  output  1  crosshair overlay enable
- pending_out  output  1  high while a staged value differs from its committed value

## Operation
- Each button is synchronised with 2 FFs, then debounced.
  - Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- A rising edge of a debounced level, with freeze_in low in that cycle, increments the staged register:
  - bg_stage: modulo 4.
  - target_stage: modulo 4.
  - chan_stage: 5 wraps to 0.
- Multiple edges within one frame accumulate.
- Commit happens in any cycle with new_frame_in high: bg_out, target_out and channel_sel_out load their staged values.
- A button edge in the same cycle as new_frame_in:
  - It updates the stage.
  - The commit takes the pre-increment stage value, so the change lands on the next frame.
- pending_out = (bg_stage≠bg_out) | (target_stage≠target_out) | (chan_stage≠channel_sel_out).
- Crosshair FSM has two states, STEADY and BLINK.
  - STEADY: crosshair_en_out = 1.
  - STEADY → BLINK: on a commit where target_stage≠target_out. Entering BLINK clears the frame counter and half counter and drives crosshair_en_out = 0.
  - BLINK: on each new_frame_in, the frame counter increments. When it reaches BLINK_PERIOD−1, it clears, crosshair_en_out toggles and the half counter increments.
  - BLINK → STEADY: after BLINK_HALVES toggles, with crosshair_en_out = 1.
  - A new target commit during BLINK restarts BLINK from zero.
- Reset, asynchronous, any time:
  - all stage and committed registers = 0; crosshair_en_out = 1; pending_out = 0; FSM = STEADY.
  - Debounced levels = 0.
  - A button held through reset therefore produces one edge after debounce.

## Timing
- Press to stage update: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Stage to output: outputs change on the clock edge that samples new_frame_in high, i.e. visible the cycle after the pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs, except that pending_out is combinational from internal registers only.
- new_frame_in with no pending change leaves the outputs unchanged, and the crosshair FSM advances only in BLINK.

## Structure
- Package video_ctrl_pkg:
  - channel code constants CH_R..CH_CB and CH_MAX = 5;
  - crosshair FSM state enum.
- Sub-module button_debouncer, instantiated three times:
  - contains the synchroniser, the stability counter sized $clog2(DEBOUNCE_CYCLES+1), and a rising-edge pulse output.
- Top level holds the stage/commit registers and the crosshair FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, BLINK_PERIOD = 2, BLINK_HALVES = 4.
1. Reset released; press btn_bg cleanly for 20 cycles, then pulse new_frame_in.
   - pending_out rises 7 cycles after the press.
   - bg_out goes 0→1 the cycle after the pulse; pending_out then returns to 0.
2. Toggle btn_channel every 2 cycles for 20 cycles, then release low.
   - No stage change.
   - A clean press repeated 7 times, then commit, gives channel_sel_out = 1 (wrap 5→0).
3. Press btn_target in the exact cycle of new_frame_in.
   - target_out stays 0 at this commit and becomes 1 at the next pulse.
4. Commit a target change, then issue 8 frame pulses.
   - crosshair_en_out sequence per frame: 0,0,1,1,0,0,1,1; then steady 1.
   - A second target commit at frame 3 restarts the sequence.
5. Hold freeze_in high during a bg press.
   - No stage change, pending_out = 0.
6. Assert rst_n_in low mid-BLINK with stages nonzero.
   - All outputs return to reset values immediately, without waiting for a clock edge.
